// File: rtl/interrupt_unit_pkg.sv
// interrupt_unit_pkg: shared vector constants, request count, FSM/source encodings and vector helper
package interrupt_unit_pkg;
  localparam int NUM_IRQ = 14;
  localparam logic [15:0] VEC_RESET = 16'hFFFE;
  localparam logic [15:0] VEC_NMI = 16'hFFFC;
  localparam logic [15:0] VEC_BASE = 16'hFFE0;
  typedef enum logic [2:0] {RESET, IDLE, PEND, SERVICE, ACK} state_t;
  typedef enum logic [1:0] {SRC_RST, SRC_NMI, SRC_IRQ} src_t;
  function automatic logic [15:0] irq_vec(input logic [3:0] idx);
    return VEC_BASE + {11'd0, idx, 1'b0};
  endfunction
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority encoder for maskable requests, highest index wins
// ports: req (requests), gie (global enable) -> valid (an enabled request exists), idx (winning index)
module irq_prio_enc
  import interrupt_unit_pkg::*;
(
  input  logic [NUM_IRQ-1:0] req,
  input  logic               gie,
  output logic               valid,
  output logic [3:0]         idx
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_IRQ; i++) idx = req[i] ? 4'(i) : idx;
    valid = gie & |req;
  end
endmodule

// File: rtl/interrupt_unit.sv
// interrupt_unit: reset/NMI/maskable-interrupt sequencer feeding the CAR latch control
// ports: clk, rst (sync, active high), irq (level requests, bit 13 highest), nmi (rising edge, only with
//   INTERRUPT_UNIT_NMI_EN), gie, IF/Br (fetch/writeback boundaries), vec_load (PC load step) ->
//   RSTREQ, INTREQ, INTACK, vector (active sequence vector), irq_clr (one-hot flag clear in ACK)
module interrupt_unit
  import interrupt_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
`ifdef INTERRUPT_UNIT_NMI_EN
  input  logic               nmi,
`endif
  input  logic               gie,
  input  logic               IF,
  input  logic               Br,
  input  logic               vec_load,
  output logic               RSTREQ,
  output logic               INTREQ,
  output logic               INTACK,
  output logic [15:0]        vector,
  output logic [NUM_IRQ-1:0] irq_clr
);
  state_t      state_q, state_d;
  src_t        src_q, src_d;
  logic [15:0] vec_q, vec_d;
  logic [3:0]  idx_q, idx_d, enc_idx;
  logic        enc_valid, nmi_req;
  irq_prio_enc u_enc (.req(irq), .gie(gie), .valid(enc_valid), .idx(enc_idx));
`ifdef INTERRUPT_UNIT_NMI_EN
  logic nmi_q, nmi_d, nmi_pend_q, nmi_pend_d, nmi_rise;
  always_comb begin
    nmi_rise = nmi & ~nmi_q;
    nmi_d = nmi;
    // a fresh edge wins over the ACK-time clear so a back-to-back NMI is not lost
    nmi_pend_d = nmi_rise | (nmi_pend_q & ~(state_q == ACK && src_q == SRC_NMI));
    // the edge itself counts so an NMI beats a maskable request arriving in the same cycle
    nmi_req = nmi_pend_q | nmi_rise;
  end
  always_ff @(posedge clk) begin
    nmi_q <= rst ? 1'b0 : nmi_d;
    nmi_pend_q <= rst ? 1'b0 : nmi_pend_d;
  end
`else
  assign nmi_req = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    vec_d = vec_q;
    idx_d = idx_q;
    case (state_q)
      RESET: begin
        state_d = SERVICE;
        src_d = SRC_RST;
        vec_d = VEC_RESET;
      end
      IDLE:
        if (nmi_req) begin
          state_d = PEND;
          src_d = SRC_NMI;
          vec_d = VEC_NMI;
        end else if (enc_valid) begin
          state_d = PEND;
          src_d = SRC_IRQ;
          vec_d = irq_vec(enc_idx);
          idx_d = enc_idx;
        end
      PEND:    state_d = (IF | Br) ? SERVICE : PEND;
      SERVICE: state_d = vec_load ? ACK : SERVICE;
      ACK:     state_d = IDLE;
      default: state_d = RESET;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET;
      src_q <= SRC_RST;
      vec_q <= VEC_RESET;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      vec_q <= vec_d;
      idx_q <= idx_d;
    end
  end
  assign RSTREQ = state_q == RESET;
  assign INTREQ = state_q == PEND;
  assign INTACK = state_q == ACK;
  assign vector = vec_q;
  assign irq_clr = (INTACK && src_q == SRC_IRQ) ? {{(NUM_IRQ-1){1'b0}}, 1'b1} << idx_q : '0;
endmodule
